// File: rtl/l1_maint_pkg.sv
// Shared types for the L1 cache maintenance controller: FSM states, sequence
// types, timeout default and phase decode helpers.
package l1_maint_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 1024;

    typedef enum logic [2:0] {
        IDLE,
        D_FLUSH,
        D_CLEAR,
        I_CLEAR,
        RELEASE,
        DONE
    } maint_state_e;

    typedef enum logic [1:0] {
        MAINT_FENCE_I,
        MAINT_FLUSH,
        MAINT_CLEAR
    } maint_e;

    // Timeout counter must hold TIMEOUT_CYCLES itself; keep at least one bit.
    function automatic int unsigned tmo_width(input int unsigned t);
        return (t == 0) ? 1 : $clog2(t + 1);
    endfunction

    // Cache request bit owned by a phase: [0] dcache_flush, [1] dcache_clear, [2] icache_clear.
    function automatic logic [2:0] phase_mask(input maint_state_e s);
        case (s)
            D_FLUSH: return 3'b001;
            D_CLEAR: return 3'b010;
            I_CLEAR: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic maint_state_e first_phase(input maint_e seq);
        return (seq == MAINT_CLEAR) ? D_CLEAR : D_FLUSH;
    endfunction

    function automatic maint_state_e next_phase(input maint_state_e ph, input maint_e seq);
        case (ph)
            D_FLUSH: return (seq == MAINT_FENCE_I) ? I_CLEAR : DONE;
            D_CLEAR: return I_CLEAR;
            default: return DONE;
        endcase
    endfunction

endpackage

// File: rtl/l1_cache_maint_ctrl_if.sv
// Pipeline request/status and cache flush/clear handshake bundle.
interface l1_cache_maint_ctrl_if;
    logic fence_i_req;
    logic flush_req;
    logic clear_req;
    logic req_ack;
    logic busy;
    logic maint_done;
    logic maint_err;
    logic dcache_flush;
    logic dcache_clear;
    logic icache_clear;
    logic dcache_flush_done;
    logic dcache_clear_done;
    logic icache_clear_done;

    // slave: the controller; master: pipeline plus caches around it.
    modport slave (
        input  fence_i_req, flush_req, clear_req,
        input  dcache_flush_done, dcache_clear_done, icache_clear_done,
        output req_ack, busy, maint_done, maint_err,
        output dcache_flush, dcache_clear, icache_clear
    );

    modport master (
        output fence_i_req, flush_req, clear_req,
        output dcache_flush_done, dcache_clear_done, icache_clear_done,
        input  req_ack, busy, maint_done, maint_err,
        input  dcache_flush, dcache_clear, icache_clear
    );
endinterface

// File: rtl/l1_maint_timeout.sv
// Per-phase watchdog: clearable saturating cycle counter with an expiry strobe.
module l1_maint_timeout
    import l1_maint_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CW = tmo_width(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Fires in the TIMEOUT_CYCLES-th cycle of a phase, so a phase never exceeds that many cycles.
    assign expired = (TIMEOUT_CYCLES != 0) && inc && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/l1_cache_maint_ctrl.sv
// Sequences D-cache flush/clear and I-cache clear for fence.i/flush/clear
// requests, one four-phase cache handshake at a time, with per-phase timeout.
module l1_cache_maint_ctrl
    import l1_maint_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input logic                 CLK,
    input logic                 nRST,
    l1_cache_maint_ctrl_if.slave bus
);

    maint_state_e st_q, st_d;
    maint_state_e ph_q, ph_d;
    maint_e       seq_q, seq_d;
    logic         err_q, err_d;
    logic [2:0]   creq_q, creq_d;
    logic [2:0]   done_v, cur_m;
    logic         any_req, in_phase, cnt_inc, cnt_clr, tmo_hit;

    assign any_req  = bus.fence_i_req | bus.flush_req | bus.clear_req;
    assign done_v   = {bus.icache_clear_done, bus.dcache_clear_done, bus.dcache_flush_done};
    assign cur_m    = phase_mask(ph_q);
    assign in_phase = (st_q == D_FLUSH) || (st_q == D_CLEAR) || (st_q == I_CLEAR);
    assign cnt_inc  = in_phase || (st_q == RELEASE);

    l1_maint_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .CLK     (CLK),
        .nRST    (nRST),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .expired (tmo_hit)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            st_q   <= IDLE;
            ph_q   <= IDLE;
            seq_q  <= MAINT_FENCE_I;
            err_q  <= 1'b0;
            creq_q <= '0;
        end else begin
            st_q   <= st_d;
            ph_q   <= ph_d;
            seq_q  <= seq_d;
            err_q  <= err_d;
            creq_q <= creq_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        ph_d    = ph_q;
        seq_d   = seq_q;
        err_d   = err_q;
        creq_d  = '0;
        cnt_clr = 1'b0;
        unique case (st_q)
            IDLE: begin
                if (any_req) begin
                    if (bus.fence_i_req)    seq_d = MAINT_FENCE_I;
                    else if (bus.flush_req) seq_d = MAINT_FLUSH;
                    else                    seq_d = MAINT_CLEAR;
                    st_d    = first_phase(seq_d);
                    ph_d    = st_d;
                    err_d   = 1'b0;
                    cnt_clr = 1'b1;
                end
            end
            D_FLUSH, D_CLEAR, I_CLEAR: begin
                // Done only counts once our own request has been visible to the cache.
                if (tmo_hit) begin
                    st_d  = IDLE;
                    err_d = 1'b1;
                end else if (|(creq_q & done_v & cur_m)) begin
                    st_d = RELEASE;
                end else begin
                    creq_d = cur_m;
                end
            end
            RELEASE: begin
                if (tmo_hit) begin
                    st_d  = IDLE;
                    err_d = 1'b1;
                end else if (!(|(done_v & cur_m))) begin
                    st_d = next_phase(ph_q, seq_q);
                    if (st_d != DONE) begin
                        ph_d    = st_d;
                        cnt_clr = 1'b1;
                    end
                end
            end
            DONE: st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    // req_ack is combinational from IDLE; gate it so reset forces every output low.
    assign bus.req_ack      = nRST && (st_q == IDLE) && any_req;
    assign bus.busy         = cnt_inc;
    assign bus.maint_done   = (st_q == DONE);
    assign bus.maint_err    = err_q;
    assign bus.dcache_flush = creq_q[0];
    assign bus.dcache_clear = creq_q[1];
    assign bus.icache_clear = creq_q[2];

endmodule

// File: tb/tb_l1_cache_maint_ctrl.sv
// Scoreboard bench for l1_cache_maint_ctrl: expected handshake events are queued
// with each stimulus and matched against events observed on the DUT outputs.
module tb_l1_cache_maint_ctrl;

    localparam int TMO     = 8;
    localparam int EV_ACK  = 1;
    localparam int EV_DF   = 2;
    localparam int EV_DC   = 3;
    localparam int EV_IC   = 4;
    localparam int EV_DONE = 5;
    localparam int EV_ERR  = 6;

    logic CLK = 1'b0;
    logic nRST;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   exp_q[$];
    int   ack_cyc = 0, done_cyc = 0, err_cyc = 0;

    // Cache model knobs
    logic zero_wait = 1'b1;
    logic stuck_lo = 1'b0;
    logic stuck_hi = 1'b0;
    int   dly = 0;
    int   drop = 0;
    logic [2:0] done_r = '0;
    int   hi[3] = '{0, 0, 0};
    int   lo[3] = '{0, 0, 0};
    logic [2:0] prev_req = '0;
    logic prev_err = 1'b0;

    l1_cache_maint_ctrl_if bus();

    l1_cache_maint_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    wire [2:0] creq  = {bus.icache_clear, bus.dcache_clear, bus.dcache_flush};
    wire [2:0] cdone = stuck_hi ? 3'b111 : stuck_lo ? 3'b000 : zero_wait ? creq : done_r;
    assign bus.dcache_flush_done = cdone[0];
    assign bus.dcache_clear_done = cdone[1];
    assign bus.icache_clear_done = cdone[2];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic got_ev(input int ev);
        if (exp_q.size() == 0) chk("unexpected_event", ev, 0);
        else chk("event_order", ev, exp_q.pop_front());
    endtask

    // Delayed cache: done rises after dly cycles of request, falls drop cycles after release.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (creq[i]) begin
                lo[i] <= 0;
                hi[i] <= hi[i] + 1;
                if (hi[i] + 1 >= dly) done_r[i] <= 1'b1;
            end else begin
                hi[i] <= 0;
                lo[i] <= lo[i] + 1;
                if (lo[i] + 1 >= drop) done_r[i] <= 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        if (nRST) begin
            if (bus.req_ack) begin ack_cyc <= cyc; got_ev(EV_ACK); end
            if (creq[0] && !prev_req[0]) got_ev(EV_DF);
            if (creq[1] && !prev_req[1]) got_ev(EV_DC);
            if (creq[2] && !prev_req[2]) got_ev(EV_IC);
            if (bus.maint_done) begin done_cyc <= cyc; got_ev(EV_DONE); end
            if (bus.maint_err && !prev_err) begin err_cyc <= cyc; got_ev(EV_ERR); end
            chk("req_exclusive", int'($countones(creq) <= 1), 1);
            prev_req <= creq;
            prev_err <= bus.maint_err;
        end
    end

    task automatic pulse(input logic fi, input logic fl, input logic cl);
        @(posedge CLK); #1;
        bus.fence_i_req = fi;
        bus.flush_req   = fl;
        bus.clear_req   = cl;
        @(posedge CLK); #1;
        bus.fence_i_req = 1'b0;
        bus.flush_req   = 1'b0;
        bus.clear_req   = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge CLK);
        while ((bus.busy || bus.maint_done || exp_q.size() != 0) && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk("idle_bound", int'(n < 300), 1);
        repeat (4) @(negedge CLK);
        chk("queue_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},   int'(bus.req_ack), 0);
        chk({tag, "_busy"},  int'(bus.busy), 0);
        chk({tag, "_done"},  int'(bus.maint_done), 0);
        chk({tag, "_err"},   int'(bus.maint_err), 0);
        chk({tag, "_creq"},  int'(creq), 0);
    endtask

    task automatic set_cache(input logic zw, input int d, input int dr);
        zero_wait = zw;
        dly       = d;
        drop      = dr;
    endtask

    initial begin
        int n;
        nRST = 1'b0;
        bus.fence_i_req = 1'b0;
        bus.flush_req   = 1'b0;
        bus.clear_req   = 1'b0;
        #1;
        chk_all_zero("rst_async");
        repeat (3) @(posedge CLK);
        #1;
        chk_all_zero("rst_clk");
        nRST = 1'b1;

        // Zero-wait fence.i: fixed 7-cycle latency
        set_cache(1'b1, 0, 0);
        exp_q.push_back(EV_ACK); exp_q.push_back(EV_DF); exp_q.push_back(EV_IC); exp_q.push_back(EV_DONE);
        pulse(1'b1, 1'b0, 1'b0);
        wait_idle();
        chk("fence_latency", done_cyc - ack_cyc, 7);

        // All three requests at once: fence.i wins, single ack
        exp_q.push_back(EV_ACK); exp_q.push_back(EV_DF); exp_q.push_back(EV_IC); exp_q.push_back(EV_DONE);
        pulse(1'b1, 1'b1, 1'b1);
        wait_idle();
        chk("prio_latency", done_cyc - ack_cyc, 7);

        // Delayed caches: done 2 cycles after request, drops 1 cycle after release
        set_cache(1'b0, 2, 1);
        exp_q.push_back(EV_ACK); exp_q.push_back(EV_DF); exp_q.push_back(EV_IC); exp_q.push_back(EV_DONE);
        pulse(1'b1, 1'b0, 1'b0);
        wait_idle();

        // flush_req re-pulsed while busy is ignored
        exp_q.push_back(EV_ACK); exp_q.push_back(EV_DF); exp_q.push_back(EV_DONE);
        pulse(1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge CLK);
        pulse(1'b0, 1'b1, 1'b0);
        wait_idle();

        // Flush with done stuck low: abort after TMO cycles in the phase
        stuck_lo = 1'b1;
        exp_q.push_back(EV_ACK); exp_q.push_back(EV_DF); exp_q.push_back(EV_ERR);
        pulse(1'b0, 1'b1, 1'b0);
        wait_idle();
        stuck_lo = 1'b0;
        chk("tmo_latency", err_cyc - ack_cyc, TMO + 1);
        chk("tmo_err_set", int'(bus.maint_err), 1);
        chk("tmo_busy_low", int'(bus.busy), 0);
        chk("tmo_flush_low", int'(bus.dcache_flush), 0);

        // Next clear_req clears maint_err on acceptance and completes normally
        set_cache(1'b1, 0, 0);
        exp_q.push_back(EV_ACK); exp_q.push_back(EV_DC); exp_q.push_back(EV_IC); exp_q.push_back(EV_DONE);
        pulse(1'b0, 1'b0, 1'b1);
        chk("err_cleared", int'(bus.maint_err), 0);
        chk("busy_after_ack", int'(bus.busy), 1);
        wait_idle();
        chk("clear_latency", done_cyc - ack_cyc, 7);

        // Done already high at phase entry: request still raised, release never seen -> timeout
        stuck_hi = 1'b1;
        exp_q.push_back(EV_ACK); exp_q.push_back(EV_DC); exp_q.push_back(EV_ERR);
        pulse(1'b0, 1'b0, 1'b1);
        wait_idle();
        stuck_hi = 1'b0;
        chk("hi_entry_err", int'(bus.maint_err), 1);

        // Reset asserted mid D_CLEAR drops everything immediately
        set_cache(1'b0, 2, 1);
        exp_q.push_back(EV_ACK); exp_q.push_back(EV_DC);
        pulse(1'b0, 1'b0, 1'b1);
        n = 0;
        while (!bus.dcache_clear && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("dclear_seen", int'(bus.dcache_clear), 1);
        #1;
        nRST = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        chk("rst_queue", exp_q.size(), 0);
        repeat (3) @(posedge CLK);
        #1;
        nRST = 1'b1;
        exp_q.push_back(EV_ACK); exp_q.push_back(EV_DC); exp_q.push_back(EV_IC); exp_q.push_back(EV_DONE);
        pulse(1'b0, 1'b0, 1'b1);
        wait_idle();
        chk("post_rst_err", int'(bus.maint_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/l1_cache_maint_ctrl.md
L1_CACHE_MAINT_CTRL -- requirements
Module: l1_cache_maint_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, max cycles any single cache phase may take before abort; 0 disables timeout.
REQ-002 CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 nRST  input  1  asynchronous, active-low reset.
REQ-004 fence_i_req  input  1  pipeline request: flush D-cache, then clear I-cache.
REQ-005 flush_req  input  1  pipeline request: flush D-cache only.
REQ-006 clear_req  input  1  pipeline request: clear D-cache, then clear I-cache.
REQ-007 req_ack  output  1  one-cycle pulse: request accepted.
REQ-008 busy  output  1  high from acceptance until done or error.
REQ-009 maint_done  output  1  one-cycle pulse: sequence completed.
REQ-010 maint_err  output  1  sticky timeout flag, cleared on next accepted request.
REQ-011 dcache_flush, dcache_clear, icache_clear  output  1 each  requests driven to caches' flush/clear inputs.
REQ-012 dcache_flush_done, dcache_clear_done, icache_clear_done  input  1 each  cache completion levels.

Function
REQ-013 FSM states: IDLE, D_FLUSH, D_CLEAR, I_CLEAR, RELEASE, DONE; encoded as enum from package.
REQ-014 Requests sampled only in IDLE; priority fence_i_req > flush_req > clear_req; lower-priority simultaneous requests ignored (not queued).
REQ-015 Acceptance: req_ack pulses in acceptance cycle; busy high from next cycle; maint_err cleared same edge.
REQ-016 Sequence: fence_i -> D_FLUSH, I_CLEAR; flush -> D_FLUSH; clear -> D_CLEAR, I_CLEAR; sequence latched in a phase register.
REQ-017 Four-phase handshake per phase: assert request registered; hold until matching done sampled high; deassert next cycle; enter RELEASE; wait for done low before next phase or DONE.
REQ-018 At most one cache request output high in any cycle; never two phases overlap.
REQ-019 Done already high on phase entry: request still asserted ≥1 cycle, completion counted only when done high while request high.
REQ-020 Minimum latency per phase 3 cycles (assert, done seen, release seen); fence_i with zero-wait caches: maint_done 7 cycles after req_ack.
REQ-021 DONE: maint_done pulses one cycle, busy low same cycle, return to IDLE next cycle.
REQ-022 Timeout counter: clears on phase entry, increments each cycle in phase incl. RELEASE, saturating; reaching TIMEOUT_CYCLES (≠0) -> drop request, set maint_err, busy low, return IDLE, no maint_done.
REQ-023 Counter width $clog2(TIMEOUT_CYCLES+1), minimum 1 bit.
REQ-024 New requests while busy ignored; req_ack not pulsed.

Reset
REQ-025 nRST low: state IDLE, all outputs 0, counter 0, phase register cleared, immediately (asynchronous).
REQ-026 Reset mid-sequence drops cache request at once; no maint_done; caches responsible for own reset.

Structure
REQ-027 Shared package l1_maint_pkg: state enum, sequence-type enum (MAINT_FENCE_I, MAINT_FLUSH, MAINT_CLEAR), default TIMEOUT constant.
REQ-028 One sub-module natural: l1_maint_timeout (loadable saturating counter + expiry flag).

Verification
REQ-029 fence_i_req 1 cycle, caches respond done 2 cycles after request, drop 1 cycle after release -> dcache_flush then icache_clear, never overlapping, single maint_done.
REQ-030 fence_i_req, flush_req, clear_req same cycle -> fence_i sequence only, one req_ack.
REQ-031 TIMEOUT_CYCLES=8, dcache_flush_done stuck low -> dcache_flush drops after 8 cycles, maint_err=1, busy=0, no maint_done; next clear_req clears maint_err.
REQ-032 Zero-wait caches, fence_i -> maint_done exactly 7 cycles after req_ack.
REQ-033 nRST asserted mid D_CLEAR -> all outputs 0 same cycle; after release, clear_req runs full sequence normally.
REQ-034 flush_req pulsed while busy -> ignored, no req_ack, no extra phase.
